muxn_pipe: RTL

- Parametrised N-input selector with a registered, flow-controlled output.
- It is the next generation of the combinational 2:1 mux, for datapath points that must cross a pipeline boundary, such as forwarding/result select feeding a stage register.
- Combinational N:1 select feeds a 2-entry skid buffer with valid/ready handshake on both sides, so it sustains full throughput under backpressure.
- Supports a synchronous flush for branch/exception squash.

---
 rtl/muxn_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/muxn_pipe.sv
// rtl/muxn_pipe.sv - N:1 select feeding a registered 2-entry skid buffer with valid/ready flow control
// Main register M drives the outputs; skid register K catches a beat accepted while downstream stalls.
module muxn_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [N*WIDTH-1:0]   d,
  input  logic [SELW-1:0]      s,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 sel_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_m_data;
  logic [WIDTH-1:0]  r_k_data;
  logic              r_m_err;
  logic              r_k_err;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [WIDTH-1:0]  w_m_data_nxt;
  logic [WIDTH-1:0]  w_k_data_nxt;
  logic              w_m_err_nxt;
  logic              w_k_err_nxt;
  logic [WIDTH-1:0]  w_sel_data;
  logic              w_sel_err;
  logic              w_accept;
  logic              w_release;

  // An unmatched select (s >= N) yields zero data with the error flag set.
  always_comb begin
    w_sel_data = '0;
    w_sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (s == SELW'(k)) begin
        w_sel_data = d[k*WIDTH +: WIDTH];
        w_sel_err  = 1'b0;
      end
    end
  end

  assign w_accept  = in_valid && r_in_ready;
  assign w_release = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_m_data_nxt = r_m_data;
    w_m_err_nxt  = r_m_err;
    w_k_data_nxt = r_k_data;
    w_k_err_nxt  = r_k_err;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt  = ST_ONE;
          w_m_data_nxt = w_sel_data;
          w_m_err_nxt  = w_sel_err;
        end
      end
      ST_ONE: begin
        if (w_accept && w_release) begin
          w_m_data_nxt = w_sel_data;
          w_m_err_nxt  = w_sel_err;
        end else if (w_release) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_state_nxt  = ST_FULL;
          w_k_data_nxt = w_sel_data;
          w_k_err_nxt  = w_sel_err;
        end
      end
      ST_FULL: begin
        if (w_release) begin
          w_state_nxt  = ST_ONE;
          w_m_data_nxt = r_k_data;
          w_m_err_nxt  = r_k_err;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Flush shares the reset path so the beat presented in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state     <= ST_EMPTY;
      r_m_data    <= '0;
      r_m_err     <= 1'b0;
      r_k_data    <= '0;
      r_k_err     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_m_data    <= w_m_data_nxt;
      r_m_err     <= w_m_err_nxt;
      r_k_data    <= w_k_data_nxt;
      r_k_err     <= w_k_err_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_m_data;
  assign sel_err   = r_m_err;

endmodule
